adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 110 +++++++++++
 tb/tb_adder_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: one shared WIDTH-bit adder serving NREQ requesters.
// A rotating-priority arbiter picks one requester per cycle (combinational
// grant); the granted operands are summed and the result is registered
// together with the owner's index and a one-cycle valid pulse.
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic                  stall,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [1:0]            res_id,
  output logic [WIDTH-1:0]      res
);

  // Priority pointer: index searched first in the next arbitration.
  logic [1:0]       ptr_r;

  // Arbitration results.
  logic [NREQ-1:0]  gnt_s;
  logic [1:0]       sel_s;
  logic             accept_s;
  logic [1:0]       cand_s;

  // Shared adder datapath.
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH-1:0] sum_s;

  // Output registers.
  logic             res_valid_r;
  logic [1:0]       res_id_r;
  logic [WIDTH-1:0] res_r;

  // Rotating-priority search: first asserted req at or above ptr, wrapping.
  always_comb begin
    gnt_s    = {NREQ{1'b0}};
    sel_s    = 2'd0;
    accept_s = 1'b0;
    cand_s   = 2'd0;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        cand_s = ptr_r + k[1:0];
        if (!accept_s && req[cand_s]) begin
          gnt_s[cand_s] = 1'b1;
          sel_s         = cand_s;
          accept_s      = 1'b1;
        end else begin
          accept_s = accept_s;
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Operand mux in front of the single adder; carry out is discarded.
  always_comb begin
    a_sel_s = {WIDTH{1'b0}};
    b_sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (sel_s == i[1:0]) begin
        a_sel_s = a_in[i*WIDTH +: WIDTH];
        b_sel_s = b_in[i*WIDTH +: WIDTH];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
    sum_s = a_sel_s + b_sel_s;
  end

  // Pointer moves just past the requester that was accepted; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 2'd0;
    end else if (accept_s) begin
      ptr_r <= sel_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Result registers: capture on accept, pulse valid, otherwise hold data.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_id_r    <= 2'd0;
      res_r       <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_id_r    <= sel_s;
      res_r       <= sum_s;
    end else begin
      res_valid_r <= 1'b0;
      res_id_r    <= res_id_r;
      res_r       <= res_r;
    end
  end

  assign gnt       = gnt_s;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res       = res_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of round-robin arbitration
// and modular addition.
module tb_adder_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic                  stall;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic [1:0]            res_id;
  logic [WIDTH-1:0]      res;

  logic [WIDTH-1:0] a_ops [NREQ];
  logic [WIDTH-1:0] b_ops [NREQ];

  // Model state.
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_res;
  int               m_id;
  int               last_g;

  int checks;
  int errors;

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .stall     (stall),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-requester operand arrays onto the DUT buses.
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*WIDTH +: WIDTH] = a_ops[i];
      b_in[i*WIDTH +: WIDTH] = b_ops[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner of round-robin search starting at m_ptr, or -1 if nobody wins.
  function automatic int model_pick(input logic r, input logic s, input logic [3:0] q);
    if (r || s) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (q[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check grant mid-cycle, update model, check outputs.
  task automatic run_cycle(input logic r, input logic s, input logic [3:0] q);
    int g;
    logic [3:0] eg;
    logic [WIDTH-1:0] sum;
    rst = r; stall = s; req = q;
    #4;
    g  = model_pick(r, s, q);
    eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
    check("gnt", {60'd0, gnt}, {60'd0, eg});
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_valid = 1'b0; m_res = '0; m_id = 0;
    end else if (g >= 0) begin
      sum     = a_ops[g] + b_ops[g];
      m_valid = 1'b1; m_res = sum; m_id = g; m_ptr = (g + 1) % NREQ;
    end else begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    check("res_valid", {63'd0, res_valid}, {63'd0, m_valid});
    check("res", {32'd0, res}, {32'd0, m_res});
    check("res_id", {62'd0, res_id}, 64'(m_id));
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_ptr = 0; m_valid = 1'b0; m_res = '0; m_id = 0; last_g = -1;
    rst = 1'b1; stall = 1'b0; req = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin a_ops[i] = '0; b_ops[i] = '0; end

    // Reset state.
    do_reset();
    do_reset();
    check("rst_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res", {32'd0, res}, 64'd0);
    check("rst_id", {62'd0, res_id}, 64'd0);

    // Single requester.
    a_ops[0] = 32'd5; b_ops[0] = 32'd4;
    run_cycle(1'b0, 1'b0, 4'b0001);
    check("single_gnt_idx", 64'(last_g), 64'd0);
    check("single_res", {32'd0, res}, 64'd9);
    check("single_valid", {63'd0, res_valid}, 64'd1);
    run_cycle(1'b0, 1'b0, 4'b0000);
    check("single_valid_drop", {63'd0, res_valid}, 64'd0);
    check("single_res_hold", {32'd0, res}, 64'd9);

    // Full contention rotation.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin a_ops[i] = i; b_ops[i] = 32'd100; end
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0, 1'b0, 4'b1111);
      check("rr_order", 64'(last_g), 64'(c % 4));
      check("rr_res", {32'd0, res}, 64'(100 + (c % 4)));
    end

    // Skip idle requesters.
    do_reset();
    run_cycle(1'b0, 1'b0, 4'b0001);
    run_cycle(1'b0, 1'b0, 4'b1001);
    check("skip_first", 64'(last_g), 64'd3);
    run_cycle(1'b0, 1'b0, 4'b1001);
    check("skip_second", 64'(last_g), 64'd0);

    // Stall holds off grants; an accept just before stall still reports.
    do_reset();
    run_cycle(1'b0, 1'b0, 4'b0010);
    run_cycle(1'b0, 1'b1, 4'b0010);
    check("stall_prev_valid", {63'd0, res_valid}, 64'd0);
    for (int c = 0; c < 2; c++) begin
      run_cycle(1'b0, 1'b1, 4'b0010);
      check("stall_valid", {63'd0, res_valid}, 64'd0);
    end
    run_cycle(1'b0, 1'b0, 4'b0010);
    check("stall_resume", 64'(last_g), 64'd1);
    check("stall_resume_valid", {63'd0, res_valid}, 64'd1);

    // Wrap-around and a plain large sum.
    do_reset();
    a_ops[2] = 32'hFFFF_FFFF; b_ops[2] = 32'd1;
    run_cycle(1'b0, 1'b0, 4'b0100);
    check("wrap_res", {32'd0, res}, 64'd0);
    check("wrap_id", {62'd0, res_id}, 64'd2);
    a_ops[1] = 32'd65035; b_ops[1] = 32'd555489;
    run_cycle(1'b0, 1'b0, 4'b0010);
    check("sum_res", {32'd0, res}, 64'd620524);

    // Reset during traffic.
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0, 4'b1111);
    run_cycle(1'b1, 1'b0, 4'b1111);
    check("mid_rst_valid", {63'd0, res_valid}, 64'd0);
    check("mid_rst_res", {32'd0, res}, 64'd0);
    run_cycle(1'b0, 1'b0, 4'b1111);
    check("mid_rst_next", 64'(last_g), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          a_ops[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          b_ops[i] = $urandom;
        end
      end
      run_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
